// File: rtl/alu_wb_if.sv
// Interface bundling the ALU-result intake and register-file writeback signals of alu_writeback_unit.
`timescale 1ns/1ps
interface alu_wb_if #(
  parameter int DATA_W = 16,
  parameter int OPC_W  = 6,
  parameter int ADDR_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic [OPC_W-1:0]  in_opcode;
  logic [ADDR_W-1:0] in_dest;
  logic              in_z;
  logic              in_n;
  logic              in_c;
  logic              in_o;
  logic              wb_valid;
  logic              wb_ready;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] wb_addr;
  logic [3:0]        flags_q;
  logic              illegal_op;

  modport slave (
    input  in_valid, in_result, in_opcode, in_dest, in_z, in_n, in_c, in_o, wb_ready,
    output in_ready, wb_valid, wb_data, wb_addr, flags_q, illegal_op
  );

  modport master (
    output in_valid, in_result, in_opcode, in_dest, in_z, in_n, in_c, in_o, wb_ready,
    input  in_ready, wb_valid, wb_data, wb_addr, flags_q, illegal_op
  );
endinterface

// File: rtl/alu_writeback_unit.sv
// ALU writeback stage: architectural flag register plus a DEPTH-entry register-write FIFO.
// Optional macro WB_FLAG_FWD_EN adds the combinational flags_fwd output.
`timescale 1ns/1ps
module alu_writeback_unit #(
  parameter int DATA_W = 16,
  parameter int OPC_W  = 6,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2
) (
  input  logic clk,
  input  logic rst_n,
  alu_wb_if.slave bus
`ifdef WB_FLAG_FWD_EN
  ,
  output logic [3:0] flags_fwd
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [OPC_W-1:0] OP_LO  = OPC_W'(6'b001010);
  localparam logic [OPC_W-1:0] OP_HI  = OPC_W'(6'b011011);
  localparam logic [OPC_W-1:0] OP_MOV = OPC_W'(6'b010000);
  localparam logic [OPC_W-1:0] OP_CMP = OPC_W'(6'b011000);
  localparam logic [OPC_W-1:0] OP_TST = OPC_W'(6'b011001);

  function automatic logic is_alu(input logic [OPC_W-1:0] op);
    return (op >= OP_LO) && (op <= OP_HI);
  endfunction

  function automatic logic is_write(input logic [OPC_W-1:0] op);
    return is_alu(op) && (op != OP_CMP) && (op != OP_TST);
  endfunction

  function automatic logic is_flag(input logic [OPC_W-1:0] op);
    return is_alu(op) && (op != OP_MOV);
  endfunction

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [3:0]        flags_r;
  logic              illegal_r;

  logic       accept;
  logic       push;
  logic       pop;
  logic       flag_upd;
  logic [3:0] in_flags;

  // Handshake decode from registered state only; in_ready never depends on wb_ready.
  assign bus.in_ready = (count < CNT_W'(DEPTH));
  assign bus.wb_valid = (count != '0);
  assign accept       = bus.in_valid && bus.in_ready;
  assign push         = accept && is_write(bus.in_opcode);
  assign flag_upd     = accept && is_flag(bus.in_opcode);
  assign pop          = bus.wb_valid && bus.wb_ready;
  assign in_flags     = {bus.in_z, bus.in_n, bus.in_c, bus.in_o};

  assign bus.wb_data    = mem_data[rd_ptr];
  assign bus.wb_addr    = mem_addr[rd_ptr];
  assign bus.flags_q    = flags_r;
  assign bus.illegal_op = illegal_r;

`ifdef WB_FLAG_FWD_EN
  assign flags_fwd = flag_upd ? in_flags : flags_r;
`endif

  // FIFO pointers, occupancy and entry storage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_addr[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= bus.in_result;
        mem_addr[wr_ptr] <= bus.in_dest;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Architectural flags and the illegal-opcode pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_r   <= '0;
      illegal_r <= 1'b0;
    end else begin
      if (flag_upd) begin
        flags_r <= in_flags;
      end
      illegal_r <= accept && !is_alu(bus.in_opcode);
    end
  end
endmodule

// File: doc/alu_writeback_unit.md
Name: alu_writeback_unit

Overview:
Downstream neighbour of the 16-bit ALU. Captures each ALU result with its opcode, destination register and Z/N/C/O flags. Maintains the architectural flag register and buffers register-file writes in a 2-entry FIFO with valid/ready handshakes on both sides. Flags-only ops (CMP, TST) update flags and generate no register write.

Parameters:
DATA_W, 16, result/writeback data width
OPC_W, 6, opcode width
ADDR_W, 4, destination register address width
DEPTH, 2, writeback FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  ALU result valid
in_ready  out  1  unit can accept an ALU result
in_result  in  DATA_W  ALU out
in_opcode  in  OPC_W  opcode that produced in_result
in_dest  in  ADDR_W  destination register
in_z, in_n, in_c, in_o  in  1 each  ALU flags
wb_valid  out  1  register-file write pending
wb_ready  in  1  register file accepts write
wb_data  out  DATA_W  write data (FIFO head)
wb_addr  out  ADDR_W  write address (FIFO head)
flags_q  out  4  architectural flags {Z,N,C,O}
illegal_op  out  1  one-cycle pulse: accepted opcode outside ALU range

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at an edge): FIFO count=0, read/write pointers=0, storage=0, wb_valid=0, wb_data=0, wb_addr=0, flags_q=0000, illegal_op=0. Pending entries are discarded; no partial write escapes.
- Accept: in_valid && in_ready at an edge. in_ready = (count < DEPTH), registered-state only. No same-cycle pass-through when full.
- Opcode classes:
  - ALU range 001010..011011.
  - Write ops: ALU range except CMP 011000 and TST 011001.
  - Flag ops: ALU range except MOV 010000.
  - Outside the range: accepted, dropped, illegal_op=1 for exactly the next cycle, flags unchanged, nothing buffered.
- Flag update: on accept of a flag op, flags_q <= {in_z,in_n,in_c,in_o}, visible the cycle after accept. Back-to-back flag ops: last accepted wins.
- Write push: on accept of a write op, {in_result,in_dest} is written at the write pointer; the pointer wraps modulo DEPTH.
- Write pop: wb_valid = (count != 0). When wb_valid && wb_ready, the read pointer advances with wrap. wb_data/wb_addr always show the head entry and are held stable while wb_valid && !wb_ready.
- Latency: an accepted write op appears on wb_valid/wb_data one cycle after accept when the FIFO was empty.
- Simultaneous push and pop: count unchanged and order preserved. With count=DEPTH, no push can occur (in_ready=0). A pop that cycle raises in_ready the next cycle.
- Flags-only and illegal ops are accepted even when the FIFO is full? No: in_ready gates all accepts uniformly, so ordering with flags is preserved.
- Count width: clog2(DEPTH)+1. Never exceeds DEPTH and never underflows.

Optional Feature:
Macro WB_FLAG_FWD_EN.
- Defined: extra output flags_fwd (4 bits). It is combinational: {in_z,in_n,in_c,in_o} when a flag op is being accepted this cycle, else flags_q. This gives a zero-latency flag view for branch logic.
- Undefined: the port and its logic are absent. Consumers use flags_q only, with one cycle of latency.

Test Plan:
- ADD 001010, in_result=0000, dest=3, Z=1 N=0 C=1 O=1, wb_ready=1 -> next cycle wb_valid=1, wb_data=0000, wb_addr=3, flags_q=1011. One cycle later wb_valid=0.
- CMP 011000, in_result=FFFD, N=1 C=1, preceded by flags_q=1011 -> flags_q=0110, wb_valid stays 0, FIFO count unchanged.
- MOV 010000, in_result=4321, dest=5, all flags 1, prior flags_q=0110 -> wb_data=4321 at addr 5, flags_q remains 0110.
- wb_ready=0; accept INC (0010, addr 1) then DEC (0009, addr 2) -> in_ready=0 after the second accept and a third in_valid is held. Raise wb_ready -> writes 0010@1 then 0009@2 in order, in_ready returns to 1 the cycle after the first pop.
- Opcode 000001 with in_valid=1 -> illegal_op pulses exactly one cycle, flags_q and FIFO unchanged.
- Two entries buffered, wb_ready=0, rst_n=0 for one edge -> wb_valid=0, flags_q=0000, in_ready=1 on the following cycle; the old entries never appear.
